plru_array: RTL
===============

Name: plru_array

Overview:
- Multi-set, parametrised tree pseudo-LRU replacement engine for the L1 data cache.
- Holds one (NUM_WAYS-1)-bit PLRU tree per set.
- Accepts hit "touch" updates from the tag pipeline and answers victim lookups one cycle later.
- Supports invalid-way preference, optional allocate-on-lookup and a bulk flush.

Parameters:
- NUM_WAYS, 8, associativity; power of 2, >= 2.
- NUM_SETS, 64, number of sets; power of 2, >= 2.
- Derived: WAY_W = $clog2(NUM_WAYS), SET_W = $clog2(NUM_SETS), TREE_W = NUM_WAYS-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous: clear every tree to all-zero.
- touch_en  in  1  hit update request.
- touch_set  in  SET_W  set index of the hit.
- touch_way  in  WAY_W  way that hit; it becomes MRU.
- vic_req  in  1  victim lookup request.
- vic_set  in  SET_W  set index of the lookup.
- vic_valid_mask  in  NUM_WAYS  per-way valid bits of the set.
- vic_alloc  in  1  with vic_req: mark the chosen victim MRU.
- vic_rsp_valid  out  1  registered; high one cycle after vic_req.
- vic_way  out  WAY_W  registered victim way.
- vic_from_invalid  out  1  victim was chosen because a way was invalid.
- vic_none  out  1  no eligible way; only with PLRU_LOCK_EN, else tied 0.

Behaviour:
- Reset: asynchronous, active-low; clock is clk only. While rst_n=0:
  - All trees = 0.
  - vic_rsp_valid=0, vic_way=0, vic_from_invalid=0, vic_none=0.
  - An in-flight lookup is dropped; no response after reset release.
- Tree encoding:
  - Heap order: node i has children 2i+1 and 2i+2; leaf order = way index.
  - Bit 0 means the victim is in the left subtree; bit 1 means right.
- Touch of way w: every node on w's root-to-leaf path is set to point away from w. Nodes off the path are unchanged.
- Victim walk: start at the root and follow the bits down to a leaf.
- Victim priority:
  - If any bit of vic_valid_mask is 0: vic_way = lowest-index invalid way, vic_from_invalid=1.
  - Otherwise: tree walk, vic_from_invalid=0.
- Latency:
  - vic_req sampled at edge N; vic_rsp_valid=1 with vic_way valid during cycle N+1.
  - vic_rsp_valid returns to 0 the cycle after, unless a new vic_req was sampled.
  - Back-to-back lookups give one response per cycle; there is no stall and no ready signal.
- Same-cycle touch and lookup on the same set: the lookup sees the tree with the touch already applied (bypass).
- Different sets in the same cycle: independent.
- vic_alloc=1:
  - At the same edge that registers the response, the chosen victim is applied as a touch.
  - This is applied after any same-set touch_en, so the victim ends MRU.
  - vic_alloc is ignored when vic_req=0.
- flush:
  - Takes effect at the next edge; all trees become 0.
  - It overrides touch and alloc in that cycle.
  - A lookup in the same cycle still responds, computed from the pre-flush state.
- Width rules:
  - Indices are full-width. Since sizes are powers of 2, no index can be out of range.
- State: trees are held in flops (NUM_SETS x TREE_W). There is no SRAM and no read latency beyond one cycle.

Optional Feature:
- Macro: PLRU_LOCK_EN.
- Defined:
  - Adds input lock_mask (NUM_WAYS); a 1 marks a way ineligible for victim selection.
  - The invalid-way search skips locked ways.
  - Tree walk: at each node, if every way in the indicated subtree is locked, take the other subtree.
  - If all ways are locked: vic_none=1, vic_way=0, vic_from_invalid=0, and vic_alloc has no effect.
  - Touches are unaffected by locks.
- Undefined:
  - lock_mask does not exist.
  - vic_none is constant 0.
  - Every way is eligible.

Test Plan (defaults NUM_WAYS=8, NUM_SETS=64):
- Reset release, then vic_req set 3 with all valid -> next cycle vic_rsp_valid=1, vic_way=0, vic_from_invalid=0.
- Touch set 5 way 0, then lookup set 5 all valid -> vic_way=4. Touch ways 0,4,2,6 in turn, then lookup -> vic_way=1. Lookup set 6 -> vic_way=0 (sets are isolated).
- vic_valid_mask=8'hFB on any tree -> vic_way=2, vic_from_invalid=1. Mask 8'h7F -> vic_way=7.
- After reset, in one cycle: touch set 9 way 0 plus vic_req set 9 with vic_alloc=1 -> vic_way=4. Following lookup on set 9 -> vic_way=2.
- Touch several sets, then flush -> every set's lookup returns 0. Assert rst_n mid-lookup -> vic_rsp_valid=0 immediately, with no response after release.
- With PLRU_LOCK_EN, reset tree:
  - lock_mask=8'h0F -> vic_way=4.
  - lock_mask=8'hFF -> vic_none=1, and the tree is unchanged despite vic_alloc.
  - lock_mask=8'h01 with way 0 invalid -> vic_from_invalid=0, tree walk result.

Source files
------------

// File: rtl/plru_array.sv
// plru_array - per-set tree pseudo-LRU with touch, victim lookup, alloc and flush.
// Optional way locking (lock_mask, vic_none) is enabled by defining PLRU_LOCK_EN.
module plru_array #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 64,
  localparam int WAY_W  = $clog2(NUM_WAYS),
  localparam int SET_W  = $clog2(NUM_SETS),
  localparam int TREE_W = NUM_WAYS - 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                touch_en,
  input  logic [SET_W-1:0]    touch_set,
  input  logic [WAY_W-1:0]    touch_way,
  input  logic                vic_req,
  input  logic [SET_W-1:0]    vic_set,
  input  logic [NUM_WAYS-1:0] vic_valid_mask,
  input  logic                vic_alloc,
  output logic                vic_rsp_valid,
  output logic [WAY_W-1:0]    vic_way,
  output logic                vic_from_invalid,
  output logic                vic_none
`ifdef PLRU_LOCK_EN
  ,
  input  logic [NUM_WAYS-1:0] lock_mask
`endif
);

  logic [TREE_W-1:0]   tree [NUM_SETS];
  logic [NUM_WAYS-1:0] locked;
  logic [TREE_W-1:0]   touched_c;
  logic [TREE_W-1:0]   cur_c;
  logic [TREE_W-1:0]   alloc_tree_c;
  logic [WAY_W-1:0]    inv_way_c;
  logic                inv_found_c;
  logic [WAY_W-1:0]    walk_way_c;
  logic [WAY_W-1:0]    way_c;
  logic                from_inv_c;
  logic                none_c;
  logic                alloc_go;

`ifdef PLRU_LOCK_EN
  assign locked = lock_mask;
`else
  assign locked = '0;
`endif

  // Every node on the root-to-leaf path of w is pointed away from w.
  function automatic logic [TREE_W-1:0] touch_tree(input logic [TREE_W-1:0] t,
                                                   input logic [WAY_W-1:0] w);
    logic [TREE_W-1:0] r;
    logic              b;
    int                node;
    r    = t;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b       = w[WAY_W-1-l];
      r[node] = ~b;
      node    = 2 * node + 1 + int'(b);
    end
    return r;
  endfunction

  // True when the subtree selected by prefix at the given depth holds an unlocked way.
  function automatic logic sub_free(input logic [NUM_WAYS-1:0] lk, input int depth,
                                    input int prefix);
    logic r;
    r = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if ((w >> (WAY_W - depth)) == prefix && !lk[w]) r = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    touched_c = touch_tree(tree[touch_set], touch_way);
    cur_c     = (touch_en && touch_set == vic_set) ? touch_tree(tree[vic_set], touch_way)
                                                   : tree[vic_set];
  end

  // Lowest-index invalid, unlocked way; iterate downward so the lowest wins.
  always_comb begin
    inv_way_c   = '0;
    inv_found_c = 1'b0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!vic_valid_mask[w] && !locked[w]) begin
        inv_way_c   = WAY_W'(w);
        inv_found_c = 1'b1;
      end
    end
  end

  always_comb begin
    int   node;
    int   prefix;
    logic b;
    walk_way_c = '0;
    node       = 0;
    prefix     = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = cur_c[node];
`ifdef PLRU_LOCK_EN
      if (!sub_free(locked, l + 1, 2 * prefix + int'(b))) b = ~b;
`endif
      walk_way_c[WAY_W-1-l] = b;
      prefix                = 2 * prefix + int'(b);
      node                  = 2 * node + 1 + int'(b);
    end
  end

  always_comb begin
    none_c       = &locked;
    from_inv_c   = inv_found_c && !none_c;
    way_c        = none_c ? '0 : (inv_found_c ? inv_way_c : walk_way_c);
    alloc_tree_c = touch_tree(cur_c, way_c);
    alloc_go     = vic_req && vic_alloc && !none_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
      vic_rsp_valid    <= 1'b0;
      vic_way          <= '0;
      vic_from_invalid <= 1'b0;
`ifdef PLRU_LOCK_EN
      vic_none         <= 1'b0;
`endif
    end else begin
      vic_rsp_valid <= vic_req;
      if (vic_req) begin
        vic_way          <= way_c;
        vic_from_invalid <= from_inv_c;
`ifdef PLRU_LOCK_EN
        vic_none         <= none_c;
`endif
      end
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
      end else begin
        if (touch_en) tree[touch_set] <= touched_c;
        // Alloc write already includes any same-set touch, so it must land last.
        if (alloc_go) tree[vic_set] <= alloc_tree_c;
      end
    end
  end

`ifndef PLRU_LOCK_EN
  assign vic_none = 1'b0;
`endif

endmodule
